ahb_split_slave_mem: RTL and testbench

- Parametrised next-generation AHB (AMBA 2) memory slave with the bus interface and storage in one block.
- Adds the following on top of the current fixed slave:
  - configurable data width and memory depth
  - programmable wait states
  - ERROR response for out-of-range addresses
  - real SPLIT behaviour: slow-region reads are split, completed in the background, and the owning master is released via a per-master hsplit bit
- Sits behind the address decoder and the read-data/response mux, and beside the arbiter.

---
 rtl/ahb_pkg.sv | 24 ++
 rtl/ahb_split_tracker.sv | 76 +++++++
 rtl/ahb_split_slave_mem.sv | 170 +++++++++++++++++
 tb/tb_ahb_split_slave_mem.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_pkg.sv
// Shared AHB (AMBA 2) encodings and FSM state types for the split-capable memory slave.
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    typedef enum logic [1:0] {
        RESP_OKAY  = 2'b00,
        RESP_ERROR = 2'b01,
        RESP_RETRY = 2'b10,
        RESP_SPLIT = 2'b11
    } hresp_e;

    localparam logic [2:0] HSIZE_BYTE  = 3'd0;
    localparam logic [2:0] HSIZE_HALF  = 3'd1;
    localparam logic [2:0] HSIZE_WORD  = 3'd2;
    localparam logic [2:0] HSIZE_DWORD = 3'd3;

    typedef enum logic [1:0] {MS_IDLE, MS_WAIT, MS_RESP1, MS_RESP2} main_state_e;
    typedef enum logic [1:0] {SS_IDLE, SS_BUSY, SS_READY} split_state_e;

endpackage

// File: rtl/ahb_split_tracker.sv
// Single outstanding split read: holds master/word/data, counts the background latency
// and issues the one-cycle hsplit release pulse to the arbiter.
module ahb_split_tracker
    import ahb_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int IDX_W       = 8,
    parameter int NUM_MASTERS = 4,
    parameter int SPLIT_LAT   = 8
) (
    input  logic                           hclk,
    input  logic                           hreset,
    input  logic                           start,
    input  logic [$clog2(NUM_MASTERS)-1:0] start_master,
    input  logic [IDX_W-1:0]               start_idx,
    input  logic [DATA_W-1:0]              start_data,
    input  logic                           snoop_en,
    input  logic [IDX_W-1:0]               snoop_idx,
    input  logic [DATA_W-1:0]              snoop_data,
    input  logic [$clog2(NUM_MASTERS)-1:0] query_master,
    input  logic [IDX_W-1:0]               query_idx,
    input  logic                           retry_done,
    output logic                           idle,
    output logic                           match_ready,
    output logic [DATA_W-1:0]              held_data,
    output logic [NUM_MASTERS-1:0]         hsplit
);
    localparam int MST_W = $clog2(NUM_MASTERS);
    localparam int CNT_W = $clog2(SPLIT_LAT + 1);

    split_state_e     state;
    logic [CNT_W-1:0] cnt;
    logic [MST_W-1:0] held_master;
    logic [IDX_W-1:0] held_idx;

    assign idle        = (state == SS_IDLE);
    assign match_ready = (state == SS_READY) && (query_master == held_master)
                         && (query_idx == held_idx);

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            state  <= SS_IDLE;
            cnt    <= '0;
            hsplit <= '0;
        end else begin
            hsplit <= '0;
            case (state)
                SS_IDLE: if (start) begin
                    state <= SS_BUSY;
                    cnt   <= CNT_W'(SPLIT_LAT);
                end
                SS_BUSY: begin
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        hsplit <= NUM_MASTERS'(1) << held_master;
                        state  <= SS_READY;
                    end
                end
                SS_READY: if (retry_done) state <= SS_IDLE;
                default: state <= SS_IDLE;
            endcase
        end
    end

    // Writes to the held word while the split is pending must not be lost on the retry.
    always_ff @(posedge hclk) begin
        if (start && state == SS_IDLE) begin
            held_master <= start_master;
            held_idx    <= start_idx;
            held_data   <= start_data;
        end else if (snoop_en && state != SS_IDLE && snoop_idx == held_idx) begin
            held_data <= snoop_data;
        end
    end

endmodule

// File: rtl/ahb_split_slave_mem.sv
// AHB memory slave with wait states, ERROR for bad address/size and real SPLIT of slow reads.
// Optional macro AHB_SLV_BYTE_LANE_EN makes writes honour hsize byte lanes.
module ahb_split_slave_mem
    import ahb_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 1,
    parameter int SPLIT_BASE  = 'h200,
    parameter int SPLIT_LAT   = 8,
    parameter int NUM_MASTERS = 4
) (
    input  logic                           hclk,
    input  logic                           hreset,
    input  logic                           hsel,
    input  logic [1:0]                     htrans,
    input  logic                           hwrite,
    input  logic [2:0]                     hsize,
    input  logic [ADDR_W-1:0]              haddr,
    input  logic [DATA_W-1:0]              hwdata,
    input  logic [$clog2(NUM_MASTERS)-1:0] hmaster,
    input  logic                           hready_in,
    output logic [DATA_W-1:0]              hrdata,
    output logic                           hready,
    output logic [1:0]                     hresp,
    output logic [NUM_MASTERS-1:0]         hsplit
);
    localparam int BYTES = DATA_W / 8;
    localparam int LB    = $clog2(BYTES);
    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [ADDR_W-1:0] MEM_LIMIT = ADDR_W'(DEPTH * BYTES);
    localparam logic [ADDR_W-1:0] SLOW_BASE = ADDR_W'(SPLIT_BASE);

    main_state_e       state;
    hresp_e            resp;
    logic [3:0]        wcnt;
    logic              wr_pend;
    logic              dp_write;
    logic [IDX_W-1:0]  dp_idx;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              accept, take, bad, slow;
    logic [IDX_W-1:0]  a_idx, rd_idx;
    logic [DATA_W-1:0] wr_data, rd_word, trk_data;
    logic              trk_idle, trk_match;
    logic              unused_htrans;

    assign unused_htrans = htrans[0];
    assign accept = hsel & hready_in & htrans[1];
    assign take   = accept && (state == MS_IDLE || state == MS_RESP2);
    assign a_idx  = haddr[LB +: IDX_W];
    assign bad    = (haddr >= MEM_LIMIT) || (hsize > 3'(LB));
    assign slow   = !hwrite && (haddr >= SLOW_BASE);
    assign hresp  = resp;

`ifdef AHB_SLV_BYTE_LANE_EN
    logic [2:0]    dp_size;
    logic [LB-1:0] dp_lo;

    function automatic logic [DATA_W-1:0] lane_merge(input logic [DATA_W-1:0] old_w,
                                                     input logic [DATA_W-1:0] new_w,
                                                     input logic [2:0] size,
                                                     input logic [LB-1:0] lo);
        logic [DATA_W-1:0] r = old_w;
        int n   = 1 << size;
        int off = int'(lo) & ~(n - 1);
        for (int b = 0; b < BYTES; b++)
            if (b >= off && b < off + n) r[8*b +: 8] = new_w[8*b +: 8];
        return r;
    endfunction

    assign wr_data = lane_merge(mem[dp_idx], hwdata, dp_size, dp_lo);
`else
    assign wr_data = hwdata;
`endif

    // A write committing this cycle is forwarded so a back-to-back read sees it.
    assign rd_idx  = (state == MS_WAIT) ? dp_idx : a_idx;
    assign rd_word = (wr_pend && dp_idx == rd_idx) ? wr_data : mem[rd_idx];

    ahb_split_tracker #(
        .DATA_W(DATA_W), .IDX_W(IDX_W), .NUM_MASTERS(NUM_MASTERS), .SPLIT_LAT(SPLIT_LAT)
    ) u_tracker (
        .hclk        (hclk),
        .hreset      (hreset),
        .start       (take && !bad && slow && trk_idle),
        .start_master(hmaster),
        .start_idx   (a_idx),
        .start_data  (rd_word),
        .snoop_en    (wr_pend),
        .snoop_idx   (dp_idx),
        .snoop_data  (wr_data),
        .query_master(hmaster),
        .query_idx   (a_idx),
        .retry_done  (take && !bad && slow && trk_match),
        .idle        (trk_idle),
        .match_ready (trk_match),
        .held_data   (trk_data),
        .hsplit      (hsplit)
    );

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            state   <= MS_IDLE;
            resp    <= RESP_OKAY;
            hready  <= 1'b1;
            hrdata  <= '0;
            wr_pend <= 1'b0;
            wcnt    <= '0;
        end else begin
            wr_pend <= 1'b0;
            case (state)
                MS_WAIT: begin
                    if (wcnt == 4'd0) begin
                        state   <= MS_IDLE;
                        hready  <= 1'b1;
                        wr_pend <= dp_write;
                        if (!dp_write) hrdata <= rd_word;
                    end else begin
                        wcnt <= wcnt - 4'd1;
                    end
                end
                MS_RESP1: begin
                    state  <= MS_RESP2;
                    hready <= 1'b1;
                end
                // IDLE and RESP2 both show hready high, so a new address phase is sampled here.
                default: begin
                    state  <= MS_IDLE;
                    hready <= 1'b1;
                    resp   <= RESP_OKAY;
                    if (take) begin
                        if (bad) begin
                            state  <= MS_RESP1;
                            hready <= 1'b0;
                            resp   <= RESP_ERROR;
                        end else if (slow && trk_match) begin
                            hrdata <= trk_data;
                        end else if (slow) begin
                            state  <= MS_RESP1;
                            hready <= 1'b0;
                            resp   <= trk_idle ? RESP_SPLIT : RESP_RETRY;
                        end else if (WAIT_STATES == 0) begin
                            wr_pend <= hwrite;
                            if (!hwrite) hrdata <= rd_word;
                        end else begin
                            state  <= MS_WAIT;
                            hready <= 1'b0;
                            wcnt   <= 4'(WAIT_STATES - 1);
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge hclk) begin
        if (take) begin
            dp_write <= hwrite;
            dp_idx   <= a_idx;
`ifdef AHB_SLV_BYTE_LANE_EN
            dp_size  <= hsize;
            dp_lo    <= haddr[LB-1:0];
`endif
        end
        if (wr_pend) mem[dp_idx] <= wr_data;
    end

endmodule

// File: tb/tb_ahb_split_slave_mem.sv
// Scoreboard bench for ahb_split_slave_mem: a pipelined master issues directed transfers,
// a bus monitor pops expected responses and hsplit pulses and compares them.
module tb_ahb_split_slave_mem;
    localparam int DATA_W = 32, ADDR_W = 32, DEPTH = 256, WAIT_STATES = 1;
    localparam int SPLIT_LAT = 8, NUM_MASTERS = 4;
    localparam logic [1:0] R_OK = 2'b00, R_ERR = 2'b01, R_RTY = 2'b10, R_SPL = 2'b11;
`ifdef AHB_SLV_BYTE_LANE_EN
    localparam logic [31:0] BYTE_EXP = 32'h1122AA44;
`else
    localparam logic [31:0] BYTE_EXP = 32'h0000AA00;
`endif

    logic        hclk = 1'b0, hreset = 1'b1, hsel = 1'b0, hwrite = 1'b0;
    logic [1:0]  htrans = 2'b00, hmaster = 2'd0, hresp;
    logic [2:0]  hsize = 3'd2;
    logic [31:0] haddr = '0, hwdata = '0, hrdata;
    logic        hready;
    logic [3:0]  hsplit;

    int checks = 0, errors = 0, cyc = 0;

    typedef struct {
        string       name;
        logic        wr;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [1:0]  m;
        logic [31:0] wd;
        int          waits;
        logic [1:0]  resp;
        logic        chkd;
        logic [31:0] data;
        logic        spl;
    } xfer_t;
    typedef struct { int cyc; logic [3:0] mask; } split_t;

    xfer_t  seq[$];
    xfer_t  sb_q[$];
    split_t sp_q[$];

    ahb_split_slave_mem #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .WAIT_STATES(WAIT_STATES),
        .SPLIT_BASE('h200), .SPLIT_LAT(SPLIT_LAT), .NUM_MASTERS(NUM_MASTERS)
    ) dut (
        .hclk(hclk), .hreset(hreset), .hsel(hsel), .htrans(htrans), .hwrite(hwrite),
        .hsize(hsize), .haddr(haddr), .hwdata(hwdata), .hmaster(hmaster),
        .hready_in(hready), .hrdata(hrdata), .hready(hready), .hresp(hresp), .hsplit(hsplit)
    );

    always #5 hclk = ~hclk;
    always @(posedge hclk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic xfer_t mk(input string name, input logic wr, input logic [31:0] addr,
                                 input logic [2:0] size, input logic [1:0] m,
                                 input logic [31:0] wd, input int waits, input logic [1:0] resp,
                                 input logic chkd, input logic [31:0] data, input logic spl);
        xfer_t t;
        t.name = name; t.wr = wr; t.addr = addr; t.size = size; t.m = m; t.wd = wd;
        t.waits = waits; t.resp = resp; t.chkd = chkd; t.data = data; t.spl = spl;
        return t;
    endfunction

    task automatic wait_ready();
        int n = 0;
        @(negedge hclk);
        while (!hready && n < 64) begin
            @(negedge hclk);
            n++;
        end
        if (!hready) begin
            checks++;
            errors++;
            $display("FAIL wait_ready_timeout actual hready=0 required=1");
        end
    endtask

    // Pipelined master: next address phase overlaps the current data phase.
    task automatic run_seq();
        xfer_t t;
        while (seq.size() > 0) begin
            t = seq.pop_front();
            hsel = 1'b1; htrans = 2'b10; hwrite = t.wr; haddr = t.addr;
            hsize = t.size; hmaster = t.m;
            sb_q.push_back(t);
            wait_ready();
            @(posedge hclk); #1;
            if (t.spl) sp_q.push_back('{cyc + SPLIT_LAT, 4'(1) << t.m});
            hwdata = t.wd; hsel = 1'b0; htrans = 2'b00;
        end
        wait_ready();
        @(posedge hclk); #1;
    endtask

    initial begin : monitor
        bit         dph;
        int         lows;
        logic [1:0] lresp;
        xfer_t      e;
        split_t     s;
        dph = 0; lows = 0; lresp = R_OK;
        forever begin
            @(negedge hclk);
            if (hreset) begin
                dph = 0;
            end else begin
                if (hsplit != 4'b0000) begin
                    if (sp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL hsplit_unexpected actual=%b required=0000 cyc=%0d", hsplit, cyc);
                    end else begin
                        s = sp_q.pop_front();
                        chk("hsplit_mask", hsplit, s.mask);
                        chk("hsplit_cycle", cyc, s.cyc);
                    end
                end
                if (dph) begin
                    if (!hready) begin
                        lows++;
                        lresp = hresp;
                    end else begin
                        dph = 0;
                        if (sb_q.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL sb_underflow actual=response required=none");
                        end else begin
                            e = sb_q.pop_front();
                            chk({e.name, "_waits"}, lows, e.waits);
                            chk({e.name, "_resp"}, hresp, e.resp);
                            if (e.resp != R_OK) chk({e.name, "_resp1"}, lresp, e.resp);
                            if (e.chkd) chk({e.name, "_rdata"}, hrdata, e.data);
                        end
                    end
                end
                if (hsel && htrans[1] && hready) begin
                    dph = 1; lows = 0; lresp = R_OK;
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : stim
        repeat (2) @(posedge hclk);
        #1;
        chk("rst_hready", hready, 1);
        chk("rst_hresp", hresp, R_OK);
        chk("rst_hrdata", hrdata, 0);
        chk("rst_hsplit", hsplit, 0);
        @(negedge hclk) hreset = 1'b0;
        @(posedge hclk); #1;

        // Plain transfers, errors, byte write
        seq.push_back(mk("w0",      1, 32'h000, 3'd2, 0, 32'h0BADF00D, 1, R_OK,  0, 0, 0));
        seq.push_back(mk("w10",     1, 32'h010, 3'd2, 0, 32'hDEADBEEF, 1, R_OK,  0, 0, 0));
        seq.push_back(mk("r10",     0, 32'h010, 3'd2, 0, 0,            1, R_OK,  1, 32'hDEADBEEF, 0));
        seq.push_back(mk("r400",    0, 32'h400, 3'd2, 0, 0,            1, R_ERR, 0, 0, 0));
        seq.push_back(mk("w400",    1, 32'h400, 3'd2, 0, 32'h12345678, 1, R_ERR, 0, 0, 0));
        seq.push_back(mk("r0",      0, 32'h000, 3'd2, 0, 0,            1, R_OK,  1, 32'h0BADF00D, 0));
        seq.push_back(mk("rsz3",    0, 32'h014, 3'd3, 0, 0,            1, R_ERR, 0, 0, 0));
        seq.push_back(mk("r10b",    0, 32'h010, 3'd2, 0, 0,            1, R_OK,  1, 32'hDEADBEEF, 0));
        seq.push_back(mk("w20",     1, 32'h020, 3'd2, 0, 32'h11223344, 1, R_OK,  0, 0, 0));
        seq.push_back(mk("wb21",    1, 32'h021, 3'd0, 0, 32'h0000AA00, 1, R_OK,  0, 0, 0));
        seq.push_back(mk("r20",     0, 32'h020, 3'd2, 0, 0,            1, R_OK,  1, BYTE_EXP, 0));
        seq.push_back(mk("w200",    1, 32'h200, 3'd2, 0, 32'hCAFEF00D, 1, R_OK,  0, 0, 0));
        seq.push_back(mk("w204",    1, 32'h204, 3'd2, 0, 32'h01020304, 1, R_OK,  0, 0, 0));
        run_seq();

        // Split by master 2, competing retries and a snooped write while SBUSY
        seq.push_back(mk("spl_m2",  0, 32'h200, 3'd2, 2, 0,            1, R_SPL, 0, 0, 1));
        seq.push_back(mk("rty_m1",  0, 32'h204, 3'd2, 1, 0,            1, R_RTY, 0, 0, 0));
        seq.push_back(mk("rty_m2",  0, 32'h200, 3'd2, 2, 0,            1, R_RTY, 0, 0, 0));
        seq.push_back(mk("snoop_w", 1, 32'h200, 3'd2, 0, 32'hFEEDFACE, 1, R_OK,  0, 0, 0));
        run_seq();
        repeat (SPLIT_LAT + 2) @(posedge hclk);
        #1;
        seq.push_back(mk("done_m2", 0, 32'h200, 3'd2, 2, 0,            0, R_OK,  1, 32'hFEEDFACE, 0));
        run_seq();

        // Reset while SBUSY drops the split silently
        seq.push_back(mk("spl_drop", 0, 32'h200, 3'd2, 2, 0,           1, R_SPL, 0, 0, 0));
        run_seq();
        @(negedge hclk);
        #2 hreset = 1'b1;
        #1;
        chk("midrst_hready", hready, 1);
        chk("midrst_hresp", hresp, R_OK);
        chk("midrst_hrdata", hrdata, 0);
        chk("midrst_hsplit", hsplit, 0);
        @(posedge hclk);
        @(negedge hclk) hreset = 1'b0;
        repeat (SPLIT_LAT + 4) @(posedge hclk);
        #1;
        seq.push_back(mk("spl_m3",  0, 32'h200, 3'd2, 3, 0,            1, R_SPL, 0, 0, 1));
        seq.push_back(mk("r10_rst", 0, 32'h010, 3'd2, 0, 0,            1, R_OK,  1, 32'hDEADBEEF, 0));
        run_seq();
        repeat (SPLIT_LAT + 2) @(posedge hclk);
        #1;
        seq.push_back(mk("done_m3", 0, 32'h200, 3'd2, 3, 0,            0, R_OK,  1, 32'hFEEDFACE, 0));
        run_seq();

        repeat (4) @(posedge hclk);
        #1;
        chk("sb_left", sb_q.size(), 0);
        chk("split_left", sp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
